// File: rtl/iir_pkg.sv
// Shared types and constants for the iir_lpf_biquad filter slice.
// Optional saturation counter is enabled with IIR_LPF_SAT_CNT_EN.
package iir_pkg;

  typedef enum logic [1:0] {
    READ,
    MAC,
    ROUND,
    WRITE
  } state_t;

  localparam int ACC_W = 64;

  localparam logic signed [15:0] DEF_B0 = 16'sd2382;
  localparam logic signed [15:0] DEF_B1 = 16'sd4764;
  localparam logic signed [15:0] DEF_B2 = 16'sd2382;
  localparam logic signed [15:0] DEF_A1 = -16'sd10992;
  localparam logic signed [15:0] DEF_A2 = 16'sd4134;

  // Round half up, then arithmetic shift back to sample scale.
  function automatic logic signed [ACC_W-1:0] rnd_shift(
    input logic signed [ACC_W-1:0] a,
    input int                      frac
  );
    logic signed [ACC_W-1:0] b;
    b = a + (ACC_W'(1) << (frac - 1));
    return b >>> frac;
  endfunction

endpackage

// File: rtl/iir_lpf_biquad_mac.sv
// Time-shared multiply-accumulate with round/saturate output register.
// Holds the clip counter when IIR_LPF_SAT_CNT_EN is defined.
module iir_mac_unit
  import iir_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sub,
  input  logic                     rnd,
  input  logic signed [DATA_W-1:0] op,
  input  logic signed [COEF_W-1:0] coef,
`ifdef IIR_LPF_SAT_CNT_EN
  output logic [15:0]              sat_count,
`endif
  output logic [DATA_W-1:0]        z
);

  localparam int PW = DATA_W + COEF_W;

  localparam logic signed [ACC_W-1:0] A_MAX =
    $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] A_MIN =
    $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rs;
  logic                    hi;
  logic                    lo;

  always_comb begin
    prod   = PW'(op) * PW'(coef);
    prod_x = ACC_W'(prod);
    rs     = rnd_shift(acc, COEF_FRAC);
    hi     = rs > A_MAX;
    lo     = rs < A_MIN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      z   <= '0;
    end else begin
      if (clr)
        acc <= '0;
      else if (en)
        acc <= sub ? acc - prod_x : acc + prod_x;
      if (rnd) begin
        unique case (1'b1)
          hi:      z <= A_MAX[DATA_W-1:0];
          lo:      z <= A_MIN[DATA_W-1:0];
          default: z <= rs[DATA_W-1:0];
        endcase
      end
    end
  end

`ifdef IIR_LPF_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      sat_count <= '0;
    else if (rnd && (hi || lo) && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: rtl/iir_lpf_biquad.sv
// Direct Form I biquad low-pass: FSM, delay line and tap sequencing.
// Define IIR_LPF_SAT_CNT_EN to expose the sat_count output.
module iir_lpf_biquad
  import iir_pkg::*;
#(
  parameter int                      DATA_W    = 32,
  parameter int                      COEF_W    = 16,
  parameter int                      COEF_FRAC = 14,
  parameter logic signed [COEF_W-1:0] B0       = DEF_B0,
  parameter logic signed [COEF_W-1:0] B1       = DEF_B1,
  parameter logic signed [COEF_W-1:0] B2       = DEF_B2,
  parameter logic signed [COEF_W-1:0] A1       = DEF_A1,
  parameter logic signed [COEF_W-1:0] A2       = DEF_A2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] input_a,
  input  logic              input_a_stb,
  output logic              input_a_ack,
  output logic [DATA_W-1:0] output_z,
  output logic              output_z_stb,
`ifdef IIR_LPF_SAT_CNT_EN
  output logic [15:0]       sat_count,
`endif
  input  logic              output_z_ack
);

  state_t                  state;
  logic [2:0]              k;
  logic signed [DATA_W-1:0] x0;
  logic signed [DATA_W-1:0] x1;
  logic signed [DATA_W-1:0] x2;
  logic signed [DATA_W-1:0] y1;
  logic signed [DATA_W-1:0] y2;
  logic signed [DATA_W-1:0] op;
  logic signed [COEF_W-1:0] coef;
  logic                    sub;
  logic                    in_xfer;
  logic                    out_xfer;

  assign in_xfer  = input_a_stb && input_a_ack;
  assign out_xfer = output_z_stb && output_z_ack;

  // Feedback taps are subtracted rather than negated, so A=-2^15 is safe.
  always_comb begin
    op   = x0;
    coef = B0;
    sub  = 1'b0;
    case (k)
      3'd1: begin
        op   = x1;
        coef = B1;
      end
      3'd2: begin
        op   = x2;
        coef = B2;
      end
      3'd3: begin
        op   = y1;
        coef = A1;
        sub  = 1'b1;
      end
      3'd4: begin
        op   = y2;
        coef = A2;
        sub  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= READ;
      k            <= '0;
      x0           <= '0;
      x1           <= '0;
      x2           <= '0;
      y1           <= '0;
      y2           <= '0;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
    end else begin
      unique case (state)
        READ: begin
          if (in_xfer) begin
            x0          <= $signed(input_a);
            k           <= '0;
            input_a_ack <= 1'b0;
            state       <= MAC;
          end else begin
            input_a_ack <= 1'b1;
          end
        end
        MAC: begin
          if (k == 3'd4)
            state <= ROUND;
          else
            k <= k + 3'd1;
        end
        ROUND: begin
          output_z_stb <= 1'b1;
          state        <= WRITE;
        end
        WRITE: begin
          if (out_xfer) begin
            x2           <= x1;
            x1           <= x0;
            y2           <= y1;
            y1           <= $signed(output_z);
            output_z_stb <= 1'b0;
            input_a_ack  <= 1'b1;
            state        <= READ;
          end
        end
        default: state <= READ;
      endcase
    end
  end

  iir_mac_unit #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == READ && in_xfer),
    .en        (state == MAC),
    .sub       (sub),
    .rnd       (state == ROUND),
    .op        (op),
    .coef      (coef),
`ifdef IIR_LPF_SAT_CNT_EN
    .sat_count (sat_count),
`endif
    .z         (output_z)
  );

endmodule

// File: tb/tb_iir_lpf_biquad.sv
// Scoreboard bench for iir_lpf_biquad: default, pass-through and
// saturating coefficient sets driven by one shared input stream.
module tb_iir_lpf_biquad;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_x = '0;
  logic        in_stb = 1'b0;
  logic        out_ack = 1'b1;

  logic [31:0] z  [3];
  logic        zs [3];
  logic        ia [3];
`ifdef IIR_LPF_SAT_CNT_EN
  logic [15:0] sc [3];
`endif

  always #5 clk = ~clk;

  iir_lpf_biquad u_dflt (
    .clk          (clk),
    .rst          (rst),
    .input_a      (in_x),
    .input_a_stb  (in_stb),
    .input_a_ack  (ia[0]),
    .output_z     (z[0]),
    .output_z_stb (zs[0]),
`ifdef IIR_LPF_SAT_CNT_EN
    .sat_count    (sc[0]),
`endif
    .output_z_ack (out_ack)
  );

  iir_lpf_biquad #(
    .B0 (16'sd16384), .B1 (16'sd0), .B2 (16'sd0),
    .A1 (16'sd0), .A2 (16'sd0)
  ) u_pt (
    .clk          (clk),
    .rst          (rst),
    .input_a      (in_x),
    .input_a_stb  (in_stb),
    .input_a_ack  (ia[1]),
    .output_z     (z[1]),
    .output_z_stb (zs[1]),
`ifdef IIR_LPF_SAT_CNT_EN
    .sat_count    (sc[1]),
`endif
    .output_z_ack (out_ack)
  );

  iir_lpf_biquad #(
    .B0 (16'sd32767), .B1 (16'sd0), .B2 (16'sd0),
    .A1 (16'sd0), .A2 (16'sd0)
  ) u_sat (
    .clk          (clk),
    .rst          (rst),
    .input_a      (in_x),
    .input_a_stb  (in_stb),
    .input_a_ack  (ia[2]),
    .output_z     (z[2]),
    .output_z_stb (zs[2]),
`ifdef IIR_LPF_SAT_CNT_EN
    .sat_count    (sc[2]),
`endif
    .output_z_ack (out_ack)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_xfer = -100;
  logic [31:0] last_z = '0;
  logic [31:0] last_exp0 = '0;
  logic [31:0] mon_e;
  logic        prev_stb = 1'b0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  longint cb0 [3] = '{2382, 16384, 32767};
  longint cb1 [3] = '{4764, 0, 0};
  longint cb2 [3] = '{2382, 0, 0};
  longint ca1 [3] = '{-10992, 0, 0};
  longint ca2 [3] = '{4134, 0, 0};
  longint mx1 [3];
  longint mx2 [3];
  longint my1 [3];
  longint my2 [3];

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input int i, input logic [31:0] xin);
    longint x, acc, r;
    x   = longint'($signed(xin));
    acc = cb0[i] * x + cb1[i] * mx1[i] + cb2[i] * mx2[i]
        - ca1[i] * my1[i] - ca2[i] * my2[i];
    r   = (acc + 64'sd8192) >>> 14;
    if (r > SMAX) r = SMAX;
    if (r < SMIN) r = SMIN;
    mx2[i] = mx1[i];
    mx1[i] = x;
    my2[i] = my1[i];
    my1[i] = r;
    return r[31:0];
  endfunction

  task automatic push_e(input int i, input logic [31:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] qpop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
    q0.delete(); q1.delete(); q2.delete();
  endtask

  // Issue one sample; a hand value, when given, replaces the default-set model.
  task automatic send(input logic [31:0] v, input bit hand = 1'b0,
                      input logic [31:0] hv = '0);
    logic [31:0] e;
    int n;
    for (int i = 0; i < 3; i++) begin
      e = model(i, v);
      if (i == 0 && hand) e = hv;
      if (i == 0) last_exp0 = e;
      push_e(i, e);
    end
    @(posedge clk); #1;
    in_stb = 1'b1;
    in_x   = v;
    n = 0;
    @(negedge clk);
    while (!ia[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ia[0]) begin
      checks++; errors++;
      $display("FAIL in_ack_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    t_xfer = cyc;
    in_stb = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst    = 1'b0;
    in_stb = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_stb", {31'd0, zs[0]}, 32'd0);
    check("rst_ack", {31'd0, ia[0]}, 32'd0);
    check("rst_z", z[0], 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    check("rel_ack", {31'd0, ia[0]}, 32'd1);
    check("rel_stb", {31'd0, zs[0]}, 32'd0);
  endtask

  // Monitor: pop and compare on every output transfer, check latency.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        if (zs[i] && out_ack) begin
          if (qsize(i) == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out%0d: got %h expected none", i, z[i]);
          end else begin
            mon_e = qpop(i);
            check($sformatf("out%0d", i), z[i], mon_e);
          end
          if (i == 0) last_z = z[0];
        end
      end
      if (zs[0] && !prev_stb)
        check("latency", 32'(cyc - t_xfer), 32'd6);
    end
    prev_stb = zs[0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    do_reset();

    send(32'd1000);
    send(32'hFFFF_FFFB);
    send(32'h7FFF_FFFF);
    wait_drain();

    do_reset();
    send(32'd16384, 1'b1, 32'd2382);
    send(32'd0, 1'b1, 32'd6362);
    for (int i = 0; i < 62; i++) send(32'd0);
    wait_drain();

    do_reset();
    send(32'h7FFF_FFFF);
    send(32'h8000_0000);
    wait_drain();
`ifdef IIR_LPF_SAT_CNT_EN
    check("sat_count", {16'd0, sc[2]}, 32'd2);
    check("sat_count_pt", {16'd0, sc[1]}, 32'd0);
`endif

    do_reset();
    @(posedge clk); #1;
    out_ack = 1'b0;
    send(32'd123456);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!zs[0] && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      check("bp_z", z[0], last_exp0);
      check("bp_stb", {31'd0, zs[0]}, 32'd1);
      check("bp_in_ack", {31'd0, ia[0]}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    @(negedge clk);
    check("bp_q0_empty", 32'(q0.size()), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("bp_no_dup", {31'd0, zs[0]}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ack = 1'b1;

    do_reset();
    send(32'd16384);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_stb", {31'd0, zs[0]}, 32'd0);
    check("mid_rst_ack", {31'd0, ia[0]}, 32'd0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    check("mid_rel_ack", {31'd0, ia[0]}, 32'd1);
    check("mid_rel_stb", {31'd0, zs[0]}, 32'd0);
    send(32'd16384, 1'b1, 32'd2382);
    send(32'd0, 1'b1, 32'd6362);
    wait_drain();

    do_reset();
    for (int i = 0; i < 200; i++) send(32'd10000);
    wait_drain();
    checks++;
    if ($signed(last_z) < 9998 || $signed(last_z) > 10002) begin
      errors++;
      $display("FAIL dc_settle: got %0d expected 10000+-2", $signed(last_z));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
